// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit.
// Lane masks are sized for the widest supported bus (2 x 16 lanes).
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  function automatic logic [31:0] lane_mask(
    input logic [1:0] size,
    input logic [3:0] ofs
  );
    logic [31:0] m;
    m = (32'd1 << (4'd1 << size)) - 32'd1;
    return m << ofs;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Purely combinational; beat halves are split from a 2-word view.
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BYTES = DATA_W / 8,
  localparam int OFS_W = $clog2(BYTES)
) (
  input  logic [OFS_W-1:0]    ofs,
  input  logic [1:0]          size,
  input  logic                sext,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [2*DATA_W-1:0] rbuf,
  output logic                split,
  output logic [BYTES-1:0]    be0,
  output logic [BYTES-1:0]    be1,
  output logic [DATA_W-1:0]   wd0,
  output logic [DATA_W-1:0]   wd1,
  output logic [DATA_W-1:0]   rdata
);

  logic [31:0]         mask;
  logic [OFS_W+4:0]    span;
  logic [2*DATA_W-1:0] sdata;
  logic [2*DATA_W-1:0] raw;
  logic [6:0]          nbits;
  logic [DATA_W-1:0]   keep;
  logic [DATA_W-1:0]   top;
  logic                sign;

  assign mask = lane_mask(size, 4'(ofs));
  assign be0  = mask[BYTES-1:0];
  assign be1  = mask[2*BYTES-1:BYTES];

  assign span  = (OFS_W+5)'(ofs) + ((OFS_W+5)'(1) << size);
  assign split = span > (OFS_W+5)'(BYTES);

  assign sdata = {{DATA_W{1'b0}}, wdata} << {ofs, 3'b000};
  assign wd0   = sdata[DATA_W-1:0];
  assign wd1   = sdata[2*DATA_W-1:DATA_W];

  // keep covers the access width; top isolates its msb for sign
  assign raw   = rbuf >> {ofs, 3'b000};
  assign nbits = 7'd8 << size;
  assign keep  = ~({DATA_W{1'b1}} << nbits);
  assign top   = keep ^ (keep >> 1);
  assign sign  = sext & (|(raw[DATA_W-1:0] & top));
  assign rdata = (raw[DATA_W-1:0] & keep)
               | (sign ? ~keep : '0);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus master: splits misaligned accesses into two beats,
// steers lanes, extends loads and optionally times out on waitrequest.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 0,
  localparam int BYTES   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] writedata,
  output logic [BYTES-1:0]  byteenable,
  input  logic [DATA_W-1:0] readdata
);

  localparam int OFS_W = $clog2(BYTES);
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic                sext_q, sext_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2*DATA_W-1:0] buf_q, buf_d, buf_nx;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                rv_q, rv_d;
  logic                err_q, err_d;

  logic                idle, strobe, done, tmo, illegal;
  logic [ADDR_W-1:0]   a_addr, a_base;
  logic [1:0]          a_size;
  logic                a_sext;
  logic [DATA_W-1:0]   a_wdata;
  logic                split;
  logic [BYTES-1:0]    be0, be1;
  logic [DATA_W-1:0]   wd0, wd1, ext;

  // in IDLE the aligner sees the live request so beat0 is registered
  assign idle    = state_q == IDLE;
  assign a_addr  = idle ? req_addr : addr_q;
  assign a_size  = idle ? req_size : size_q;
  assign a_sext  = idle ? req_signed : sext_q;
  assign a_wdata = idle ? req_wdata : wdata_q;
  assign a_base  = {a_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  assign buf_nx = (state_q == BEAT1)
                ? {readdata, buf_q[DATA_W-1:0]}
                : {buf_q[2*DATA_W-1:DATA_W], readdata};

  mau_lane_align #(.DATA_W(DATA_W)) u_align (
    .ofs   (a_addr[OFS_W-1:0]),
    .size  (a_size),
    .sext  (a_sext),
    .wdata (a_wdata),
    .rbuf  (buf_nx),
    .split (split),
    .be0   (be0),
    .be1   (be1),
    .wd0   (wd0),
    .wd1   (wd1),
    .rdata (ext)
  );

  assign strobe  = read_q | write_q;
  assign done    = strobe & ~waitrequest;
  assign tmo     = (MAX_WAIT > 0) && strobe && waitrequest
                && (32'(wcnt_q) + 32'd1 == 32'(MAX_WAIT));
  assign illegal = (5'd1 << req_size) > 5'(BYTES);

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    sext_d    = sext_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    address_d = address_q;
    wd_d      = wd_q;
    be_d      = be_q;
    buf_d     = buf_q;
    wcnt_d    = wcnt_q;
    read_d    = read_q;
    write_d   = write_q;
    rv_d      = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          sext_d  = req_signed;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (illegal) begin
            state_d = RESP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = BEAT0;
            read_d    = ~req_write;
            write_d   = req_write;
            address_d = a_base;
            be_d      = be0;
            wd_d      = wd0;
            wcnt_d    = '0;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (done) begin
          buf_d = buf_nx;
          if (state_q == BEAT0 && split) begin
            state_d   = BEAT1;
            address_d = address_q + ADDR_W'(BYTES);
            be_d      = be1;
            wd_d      = wd1;
            wcnt_d    = '0;
          end else begin
            state_d   = RESP;
            read_d    = 1'b0;
            write_d   = 1'b0;
            address_d = '0;
            be_d      = '0;
            wd_d      = '0;
            rv_d      = 1'b1;
            rdata_d   = wr_q ? '0 : ext;
          end
        end else if (tmo) begin
          state_d   = RESP;
          read_d    = 1'b0;
          write_d   = 1'b0;
          address_d = '0;
          be_d      = '0;
          wd_d      = '0;
          rv_d      = 1'b1;
          err_d     = 1'b1;
        end else if (waitrequest) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      sext_q    <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      address_q <= '0;
      wd_q      <= '0;
      be_q      <= '0;
      buf_q     <= '0;
      wcnt_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      sext_q    <= sext_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      address_q <= address_d;
      wd_q      <= wd_d;
      be_q      <= be_d;
      buf_q     <= buf_d;
      wcnt_q    <= wcnt_d;
      read_q    <= read_d;
      write_q   <= write_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign req_ready  = idle;
  assign busy       = ~idle;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = wd_q;
  assign byteenable = be_q;
  assign resp_valid = rv_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed bus scenarios plus random
// loads/stores against a byte-array model of memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  bit         mem_init = 0;
  int         ncompl = 0;
  int         nstrobe = 0;
  int         nresp = 0;

  bit          wr_force = 0;
  bit          rnd_wait = 0;
  int          run = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_lo = '0;
  logic [31:0] ovr_hi = '0;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .busy        (busy),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic w;
    if (rnd_wait) begin
      w = (run >= 3) ? 1'b0 : ($urandom_range(0, 2) == 0);
      run = w ? run + 1 : 0;
      waitrequest = w;
    end else begin
      run = 0;
      waitrequest = wr_force;
    end
  end

  always_comb begin
    readdata = '0;
    if (ovr_en) begin
      readdata = address[2] ? ovr_hi : ovr_lo;
    end else begin
      for (int i = 0; i < 4; i++)
        readdata[8*i +: 8] = mem[(int'(address[9:0]) + i) % 1024];
    end
  end

  // bus slave memory and event counters
  always @(posedge clk) begin
    if (!reset && !mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem_init = 1;
    end
    if (reset) begin
      if (read || write) nstrobe++;
      if ((read || write) && !waitrequest) ncompl++;
      if (resp_valid) nresp++;
      if (write && !waitrequest)
        for (int i = 0; i < 4; i++)
          if (byteenable[i])
            mem[(int'(address[9:0]) + i) % 1024] = writedata[8*i +: 8];
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output bit to);
    issue(w, sz, sg, a, wd);
    to = 1;
    rd = '0;
    er = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd = resp_rdata;
        er = resp_err;
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b busy=%b want 1/0",
               req_ready, busy);
    end
    checks++;
    if ({read, write, byteenable, address, writedata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: r=%b w=%b be=%b a=%h wd=%h want 0",
               read, write, byteenable, address, writedata);
    end
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_resp: v=%b e=%b d=%h want 0",
               resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_word_store();
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({read, write, address, byteenable, writedata}
        !== {1'b0, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL word_store_beat: r=%b w=%b a=%h be=%b wd=%h want 0 1 100 1111 deadbeef",
               read, write, address, byteenable, writedata);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, write} !== 3'b100) begin
      errors++;
      $display("FAIL word_store_resp: v=%b e=%b w=%b want 1 0 0",
               resp_valid, resp_err, write);
    end
  endtask

  task automatic test_byte_load();
    ovr_en = 1;
    ovr_lo = 32'h80000000;
    for (int s = 1; s >= 0; s--) begin
      issue(1'b0, 2'd0, 1'(s), 32'h103, '0);
      @(negedge clk);
      checks++;
      if ({read, write, address, byteenable}
          !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
        errors++;
        $display("FAIL byte_load_beat: r=%b w=%b a=%h be=%b want 1 0 100 1000",
                 read, write, address, byteenable);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 ||
          resp_rdata !== (s ? 32'hFFFFFF80 : 32'h00000080)) begin
        errors++;
        $display("FAIL byte_load_s%0d: v=%b e=%b d=%h want 1 0 %h", s,
                 resp_valid, resp_err, resp_rdata,
                 (s ? 32'hFFFFFF80 : 32'h00000080));
      end
    end
    ovr_en = 0;
  endtask

  task automatic test_misaligned_load();
    ovr_en = 1;
    ovr_lo = 32'h22119988;
    ovr_hi = 32'h77664433;
    issue(1'b0, 2'd2, 1'b0, 32'h102, '0);
    @(negedge clk);
    checks++;
    if ({read, address, byteenable} !== {1'b1, 32'h100, 4'b1100}) begin
      errors++;
      $display("FAIL mis_beat0: r=%b a=%h be=%b want 1 100 1100",
               read, address, byteenable);
    end
    @(negedge clk);
    checks++;
    if ({read, address, byteenable} !== {1'b1, 32'h104, 4'b0011}) begin
      errors++;
      $display("FAIL mis_beat1: r=%b a=%h be=%b want 1 104 0011",
               read, address, byteenable);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h44332211) begin
      errors++;
      $display("FAIL mis_resp: v=%b d=%h want 1 44332211",
               resp_valid, resp_rdata);
    end
    ovr_en = 0;
  endtask

  task automatic test_stall();
    int c0, r0;
    @(posedge clk);
    #1 wr_force = 1;
    c0 = ncompl;
    r0 = nresp;
    issue(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000ABCD);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if ({write, address, byteenable, writedata}
          !== {1'b1, 32'h100, 4'b0110, 32'h00ABCD00}) begin
        errors++;
        $display("FAIL stall_hold_%0d: w=%b a=%h be=%b wd=%h want 1 100 0110 00abcd00",
                 i, write, address, byteenable, writedata);
      end
      if (i == 3) #1 wr_force = 0;
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_resp: v=%b e=%b want 1 0",
               resp_valid, resp_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ncompl - c0 != 1 || nresp - r0 != 1) begin
      errors++;
      $display("FAIL stall_counts: compl=%0d resp=%0d want 1 1",
               ncompl - c0, nresp - r0);
    end
    checks++;
    if ({mem[258], mem[257]} !== 16'hABCD) begin
      errors++;
      $display("FAIL stall_mem: got %h want abcd", {mem[258], mem[257]});
    end
  endtask

  task automatic test_timeout();
    @(posedge clk);
    #1 wr_force = 1;
    issue(1'b0, 2'd2, 1'b0, 32'h200, '0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (read !== 1'b1 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait_%0d: r=%b v=%b want 1 0",
                 i, read, resp_valid);
      end
    end
    @(negedge clk);
    checks++;
    if ({read, resp_valid, resp_err, resp_rdata}
        !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL timeout_resp: r=%b v=%b e=%b d=%h want 0 1 1 0",
               read, resp_valid, resp_err, resp_rdata);
    end
    #1 wr_force = 0;
  endtask

  task automatic test_illegal();
    int s0;
    s0 = nstrobe;
    issue(1'b0, 2'd3, 1'b1, 32'h10, '0);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata, read, write}
        !== {1'b1, 1'b1, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL illegal_resp: v=%b e=%b d=%h r=%b w=%b want 1 1 0 0 0",
               resp_valid, resp_err, resp_rdata, read, write);
    end
    @(negedge clk);
    checks++;
    if (nstrobe != s0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_nobus: strobes=%0d v=%b rdy=%b want 0 0 1",
               nstrobe - s0, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_beat();
    int r0;
    r0 = nresp;
    issue(1'b1, 2'd2, 1'b0, 32'hFE, 32'h12345678);
    @(negedge clk);
    checks++;
    if ({write, address, byteenable, writedata}
        !== {1'b1, 32'hFC, 4'b1100, 32'h56780000}) begin
      errors++;
      $display("FAIL split_beat0: w=%b a=%h be=%b wd=%h want 1 fc 1100 56780000",
               write, address, byteenable, writedata);
    end
    @(negedge clk);
    checks++;
    if ({write, address, byteenable, writedata}
        !== {1'b1, 32'h100, 4'b0011, 32'h00001234}) begin
      errors++;
      $display("FAIL split_beat1: w=%b a=%h be=%b wd=%h want 1 100 0011 00001234",
               write, address, byteenable, writedata);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({write, byteenable, busy, resp_valid} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: w=%b be=%b busy=%b v=%b want 0",
               write, byteenable, busy, resp_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (nresp != r0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_noresp: resp=%0d rdy=%b want 0 1",
               nresp - r0, req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, a, exp;
    logic [63:0] v;
    logic [1:0]  sz;
    logic        w, sg, er, xerr;
    bit          to;
    int          n, bad;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    rnd_wait = 1;
    for (int t = 0; t < 300; t++) begin
      n  = $urandom_range(0, 15);
      sz = (n == 15) ? 2'd3 : 2'(n % 3);
      w  = 1'($urandom);
      sg = 1'($urandom);
      a  = 32'h300 + $urandom_range(0, 'hEF);
      wd = $urandom;
      exp  = '0;
      xerr = (sz == 2'd3);
      if (!xerr) begin
        n = 1 << sz;
        if (w) begin
          for (int b = 0; b < n; b++) ref_mem[a + b] = wd[8*b +: 8];
        end else begin
          v = '0;
          for (int b = 0; b < n; b++)
            v = v | (64'(ref_mem[a + b]) << (8 * b));
          if (sg && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
          exp = v[31:0];
        end
      end
      do_req(w, sz, sg, a, wd, rd, er, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL rand_%0d_timeout: no resp_valid within 60 cycles",
                 t);
      end else if (rd !== exp || er !== xerr) begin
        errors++;
        $display("FAIL rand_%0d: w=%b sz=%0d sg=%b a=%h got d=%h e=%b want d=%h e=%b",
                 t, w, sz, sg, a, rd, er, exp, xerr);
      end
    end
    rnd_wait = 0;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 'h300; i < 'h400; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_mem: %0d bytes differ want 0", bad);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_word_store();
    test_byte_load();
    test_misaligned_load();
    test_stall();
    test_timeout();
    test_illegal();
    test_reset_mid_beat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
